exe_alu_branch: RTL and testbench

//   Execute-stage compute core of the 5-stage MIPS-style pipeline: a 32-bit ALU plus branch resolution.

---
 rtl/exe_pkg.sv | 34 +++
 rtl/alu_core.sv | 55 +++++
 rtl/exe_alu_branch.sv | 94 +++++++++
 tb/tb_exe_alu_branch.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared widths and opcode encodings for the execute-stage ALU and branch unit.
package exe_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ALUOP_W = 5;
    localparam int unsigned BROP_W  = 4;
    localparam int unsigned JIDX_W  = 26;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = 5'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = 5'd1;
    localparam logic [ALUOP_W-1:0] ALU_AND   = 5'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR    = 5'd3;
    localparam logic [ALUOP_W-1:0] ALU_XOR   = 5'd4;
    localparam logic [ALUOP_W-1:0] ALU_NOR   = 5'd5;
    localparam logic [ALUOP_W-1:0] ALU_SLT   = 5'd6;
    localparam logic [ALUOP_W-1:0] ALU_SLTU  = 5'd7;
    localparam logic [ALUOP_W-1:0] ALU_SLL   = 5'd8;
    localparam logic [ALUOP_W-1:0] ALU_SRL   = 5'd9;
    localparam logic [ALUOP_W-1:0] ALU_SRA   = 5'd10;
    localparam logic [ALUOP_W-1:0] ALU_LUI   = 5'd11;
    localparam logic [ALUOP_W-1:0] ALU_PASSA = 5'd12;
    localparam logic [ALUOP_W-1:0] ALU_PASSB = 5'd13;

    localparam logic [BROP_W-1:0] BR_NONE = 4'd0;
    localparam logic [BROP_W-1:0] BR_BEQ  = 4'd1;
    localparam logic [BROP_W-1:0] BR_BNE  = 4'd2;
    localparam logic [BROP_W-1:0] BR_BLEZ = 4'd3;
    localparam logic [BROP_W-1:0] BR_BGTZ = 4'd4;
    localparam logic [BROP_W-1:0] BR_BLTZ = 4'd5;
    localparam logic [BROP_W-1:0] BR_BGEZ = 4'd6;
    localparam logic [BROP_W-1:0] BR_J    = 4'd7;
    localparam logic [BROP_W-1:0] BR_JR   = 4'd8;

endpackage

// File: rtl/alu_core.sv
// Purely combinational 32-bit ALU. Signed overflow detection for ADD/SUB is
// built only when ALU_OVERFLOW_EN is defined; otherwise o_ovf is tied low.
module alu_core
    import exe_pkg::*;
(
    input  logic [4:0]  i_aluop,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result,
    output logic        o_ovf
);

    logic [31:0] sum;
    logic [31:0] diff;
    logic [4:0]  shamt;

    assign sum   = i_a + i_b;
    assign diff  = i_a - i_b;
    assign shamt = i_a[4:0];

    always_comb begin
        o_result = '0;
        case (i_aluop)
            ALU_ADD:   o_result = sum;
            ALU_SUB:   o_result = diff;
            ALU_AND:   o_result = i_a & i_b;
            ALU_OR:    o_result = i_a | i_b;
            ALU_XOR:   o_result = i_a ^ i_b;
            ALU_NOR:   o_result = ~(i_a | i_b);
            ALU_SLT:   o_result = {31'b0, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU:  o_result = {31'b0, (i_a < i_b)};
            ALU_SLL:   o_result = i_b << shamt;
            ALU_SRL:   o_result = i_b >> shamt;
            ALU_SRA:   o_result = 32'($signed(i_b) >>> shamt);
            ALU_LUI:   o_result = {i_b[15:0], 16'h0000};
            ALU_PASSA: o_result = i_a;
            ALU_PASSB: o_result = i_b;
            default:   o_result = '0;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    always_comb begin
        o_ovf = 1'b0;
        case (i_aluop)
            ALU_ADD: o_ovf = (i_a[31] == i_b[31]) && (sum[31] != i_a[31]);
            ALU_SUB: o_ovf = (i_a[31] != i_b[31]) && (diff[31] != i_a[31]);
            default: o_ovf = 1'b0;
        endcase
    end
`else
    assign o_ovf = 1'b0;
`endif

endmodule

// File: rtl/exe_alu_branch.sv
// Execute-stage core: ALU, branch resolution and EX/MEM output registers.
// Optional signed-overflow flag enabled by defining ALU_OVERFLOW_EN.
module exe_alu_branch
    import exe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic [4:0]  i_aluop,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [3:0]  i_brop,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic [25:0] i_target,
    input  logic [31:0] i_pc,
    output logic [31:0] o_alu_out,
    output logic [31:0] o_pc,
    output logic        o_clr,
    output logic        o_ovf
);

    logic [31:0] alu_res;
    logic        alu_ovf;
    logic [31:0] br_off;
    logic        taken;
    logic [31:0] target;

    logic [31:0] alu_out_d, alu_out_q;
    logic [31:0] pc_d, pc_q;
    logic        clr_d, clr_q;
    logic        ovf_d, ovf_q;

    alu_core u_alu_core (
        .i_aluop  (i_aluop),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_result (alu_res),
        .o_ovf    (alu_ovf)
    );

    // Word offset of imm16, sign-extended to 32 bits.
    assign br_off = {{14{i_target[15]}}, i_target[15:0], 2'b00};

    always_comb begin
        taken  = 1'b0;
        target = i_pc + br_off;
        case (i_brop)
            BR_BEQ:  taken = (i_rs1 == i_rs2);
            BR_BNE:  taken = (i_rs1 != i_rs2);
            BR_BLEZ: taken = i_rs1[31] || (i_rs1 == '0);
            BR_BGTZ: taken = !i_rs1[31] && (i_rs1 != '0);
            BR_BLTZ: taken = i_rs1[31];
            BR_BGEZ: taken = !i_rs1[31];
            BR_J: begin
                taken  = 1'b1;
                target = {i_pc[31:28], i_target, 2'b00};
            end
            BR_JR: begin
                taken  = 1'b1;
                target = i_rs1;
            end
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        alu_out_d = alu_res;
        pc_d      = taken ? target : i_pc;
        clr_d     = taken;
        ovf_d     = alu_ovf;
    end

    // Stall freezes every output register, including a pending flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out_q <= '0;
            pc_q      <= '0;
            clr_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (!i_stall) begin
            alu_out_q <= alu_out_d;
            pc_q      <= pc_d;
            clr_q     <= clr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_alu_out = alu_out_q;
    assign o_pc      = pc_q;
    assign o_clr     = clr_q;
    assign o_ovf     = ovf_q;

endmodule

// File: tb/tb_exe_alu_branch.sv
// Scoreboard bench for exe_alu_branch: directed vectors push expected outputs,
// a negedge monitor pops and compares one cycle after each issue.
module tb_exe_alu_branch;
    import exe_pkg::*;

`ifdef ALU_OVERFLOW_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] alu;
        logic [31:0] pc;
        logic        clr;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_stall;
    logic [4:0]  i_aluop;
    logic [31:0] i_a, i_b, i_rs1, i_rs2, i_pc;
    logic [3:0]  i_brop;
    logic [25:0] i_target;
    logic [31:0] o_alu_out, o_pc;
    logic        o_clr, o_ovf;

    exp_t sb[$];
    exp_t prev_exp;
    logic issued   = 1'b0;
    logic issued_q = 1'b0;
    int   n_vec    = 0;
    int   n_err    = 0;

    exe_alu_branch dut (
        .clk       (clk),
        .rst       (rst),
        .i_stall   (i_stall),
        .i_aluop   (i_aluop),
        .i_a       (i_a),
        .i_b       (i_b),
        .i_brop    (i_brop),
        .i_rs1     (i_rs1),
        .i_rs2     (i_rs2),
        .i_target  (i_target),
        .i_pc      (i_pc),
        .o_alu_out (o_alu_out),
        .o_pc      (o_pc),
        .o_clr     (o_clr),
        .o_ovf     (o_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) issued_q <= issued;

    // Monitor: one expectation per edge that captured an issued vector.
    always @(negedge clk) begin
        if (issued_q) begin
            exp_t e;
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_underflow: output present but no expectation queued");
            end else begin
                e = sb.pop_front();
                if (o_alu_out !== e.alu || o_pc !== e.pc || o_clr !== e.clr || o_ovf !== e.ovf) begin
                    n_err++;
                    $display("FAIL %s: got alu=%h pc=%h clr=%b ovf=%b exp alu=%h pc=%h clr=%b ovf=%b",
                             e.name, o_alu_out, o_pc, o_clr, o_ovf, e.alu, e.pc, e.clr, e.ovf);
                end
            end
        end
    end

    task automatic drive(input string nm, input logic stall,
                         input logic [4:0] aluop, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] brop, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [25:0] tgt, input logic [31:0] pc,
                         input logic [31:0] e_alu, input logic [31:0] e_pc,
                         input logic e_clr, input logic e_ovf);
        exp_t e;
        @(posedge clk);
        #1;
        i_stall = stall; i_aluop = aluop; i_a = a; i_b = b;
        i_brop = brop; i_rs1 = rs1; i_rs2 = rs2; i_target = tgt; i_pc = pc;
        issued = 1'b1;
        if (stall) begin
            e = prev_exp;
            e.name = nm;
        end else begin
            e.name = nm; e.alu = e_alu; e.pc = e_pc; e.clr = e_clr; e.ovf = e_ovf;
            prev_exp = e;
        end
        sb.push_back(e);
    endtask

    task automatic finish_issue();
        @(posedge clk);
        #1;
        issued  = 1'b0;
        i_stall = 1'b0;
        i_brop  = BR_NONE;
        @(negedge clk);
    endtask

    task automatic chk_zero(input string nm);
        n_vec++;
        if (o_alu_out !== 32'h0 || o_pc !== 32'h0 || o_clr !== 1'b0 || o_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got alu=%h pc=%h clr=%b ovf=%b exp all zero",
                     nm, o_alu_out, o_pc, o_clr, o_ovf);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; i_stall = 1'b0; i_aluop = '0; i_a = '0; i_b = '0;
        i_brop = '0; i_rs1 = '0; i_rs2 = '0; i_target = '0; i_pc = '0;
        prev_exp = '{name: "none", alu: 32'h0, pc: 32'h0, clr: 1'b0, ovf: 1'b0};
        #1;
        chk_zero("reset_init");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ALU ops
        drive("add_ovf",  0, ALU_ADD,  32'h7FFF_FFFF, 32'h1, BR_NONE, 0, 0, 0, 32'h10, 32'h8000_0000, 32'h10, 0, OVF_ON);
        drive("sub_0_1",  0, ALU_SUB,  32'h0, 32'h1,           BR_NONE, 0, 0, 0, 32'h14, 32'hFFFF_FFFF, 32'h14, 0, 0);
        drive("sub_ovf",  0, ALU_SUB,  32'h8000_0000, 32'h1,   BR_NONE, 0, 0, 0, 32'h18, 32'h7FFF_FFFF, 32'h18, 0, OVF_ON);
        drive("slt",      0, ALU_SLT,  32'hFFFF_FFFF, 32'h1,   BR_NONE, 0, 0, 0, 32'h1C, 32'h1, 32'h1C, 0, 0);
        drive("sltu",     0, ALU_SLTU, 32'hFFFF_FFFF, 32'h1,   BR_NONE, 0, 0, 0, 32'h20, 32'h0, 32'h20, 0, 0);
        drive("sra",      0, ALU_SRA,  32'h4, 32'h8000_0000,   BR_NONE, 0, 0, 0, 32'h24, 32'hF800_0000, 32'h24, 0, 0);
        drive("srl",      0, ALU_SRL,  32'h4, 32'h8000_0000,   BR_NONE, 0, 0, 0, 32'h28, 32'h0800_0000, 32'h28, 0, 0);
        drive("sll",      0, ALU_SLL,  32'h24, 32'h1,          BR_NONE, 0, 0, 0, 32'h2C, 32'h10, 32'h2C, 0, 0);
        drive("lui",      0, ALU_LUI,  32'h0, 32'hABCD_1234,   BR_NONE, 0, 0, 0, 32'h30, 32'h1234_0000, 32'h30, 0, 0);
        drive("nor",      0, ALU_NOR,  32'h0F0F_0000, 32'h0000_00F0, BR_NONE, 0, 0, 0, 32'h34, 32'hF0F0_FF0F, 32'h34, 0, 0);
        drive("xor",      0, ALU_XOR,  32'hFF00_FF00, 32'h0FF0_0FF0, BR_NONE, 0, 0, 0, 32'h38, 32'hF0F0_F0F0, 32'h38, 0, 0);
        drive("and",      0, ALU_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, BR_NONE, 0, 0, 0, 32'h3C, 32'h0F00_0F00, 32'h3C, 0, 0);
        drive("or",       0, ALU_OR,   32'hFF00_FF00, 32'h0FF0_0FF0, BR_NONE, 0, 0, 0, 32'h40, 32'hFFF0_FFF0, 32'h40, 0, 0);
        drive("passb",    0, ALU_PASSB, 32'h1, 32'hCAFE_F00D,  BR_NONE, 0, 0, 0, 32'h44, 32'hCAFE_F00D, 32'h44, 0, 0);
        drive("aluop20",  0, 5'd20,    32'h1234, 32'h5678,     BR_NONE, 0, 0, 0, 32'h48, 32'h0, 32'h48, 0, 0);

        // Branches and jumps
        drive("beq_taken", 0, ALU_ADD, 32'h3, 32'h4, BR_BEQ, 32'h5, 32'h5, 26'h000FFFF, 32'h100, 32'h7, 32'hFC, 1, 0);
        drive("bne_not",   0, ALU_ADD, 32'h3, 32'h4, BR_BNE, 32'h5, 32'h5, 26'h000FFFF, 32'h100, 32'h7, 32'h100, 0, 0);
        drive("blez_zero", 0, ALU_PASSA, 32'h1, 32'h0, BR_BLEZ, 32'h0, 32'h0, 26'h0000002, 32'h1000, 32'h1, 32'h1008, 1, 0);
        drive("bgtz_zero", 0, ALU_PASSA, 32'h2, 32'h0, BR_BGTZ, 32'h0, 32'h0, 26'h0000002, 32'h1000, 32'h2, 32'h1000, 0, 0);
        drive("bgtz_pos",  0, ALU_PASSA, 32'h3, 32'h0, BR_BGTZ, 32'h7, 32'h0, 26'h0000002, 32'h1000, 32'h3, 32'h1008, 1, 0);
        drive("bltz_min",  0, ALU_PASSA, 32'h4, 32'h0, BR_BLTZ, 32'h8000_0000, 32'h0, 26'h0000002, 32'h1000, 32'h4, 32'h1008, 1, 0);
        drive("bgez_neg",  0, ALU_PASSA, 32'h5, 32'h0, BR_BGEZ, 32'hFFFF_FFFF, 32'h0, 26'h0000002, 32'h1000, 32'h5, 32'h1000, 0, 0);
        drive("j",         0, ALU_PASSA, 32'h9000_0004, 32'h0, BR_J, 32'h0, 32'h0, 26'h0000010, 32'h9000_0004, 32'h9000_0004, 32'h9000_0040, 1, 0);
        drive("jr",        0, ALU_PASSA, 32'h6, 32'h0, BR_JR, 32'h400, 32'h0, 26'h0, 32'h200, 32'h6, 32'h400, 1, 0);
        drive("brop12",    0, ALU_PASSA, 32'h7, 32'h0, 4'd12, 32'h400, 32'h400, 26'h0000004, 32'h200, 32'h7, 32'h200, 0, 0);

        // Stall over a taken branch, then release
        drive("pre_stall", 0, ALU_PASSA, 32'hABCD, 32'h0, BR_NONE, 0, 0, 0, 32'h300, 32'hABCD, 32'h300, 0, 0);
        drive("stall_1",   1, ALU_ADD, 32'h1, 32'h1, BR_BEQ, 32'h9, 32'h9, 26'h0000004, 32'h500, 32'h0, 32'h0, 0, 0);
        drive("stall_2",   1, ALU_ADD, 32'h1, 32'h1, BR_BEQ, 32'h9, 32'h9, 26'h0000004, 32'h500, 32'h0, 32'h0, 0, 0);
        drive("stall_rel", 0, ALU_ADD, 32'h1, 32'h1, BR_BEQ, 32'h9, 32'h9, 26'h0000004, 32'h500, 32'h2, 32'h510, 1, 0);
        drive("post_br",   0, ALU_PASSB, 32'h0, 32'h55, BR_NONE, 0, 0, 0, 32'h504, 32'h55, 32'h504, 0, 0);
        finish_issue();

        // Asynchronous reset while outputs are nonzero
        #2;
        rst = 1'b1;
        #1;
        chk_zero("rst_async");
        @(posedge clk);
        #1;
        chk_zero("rst_held");
        @(negedge clk);
        rst = 1'b0;
        prev_exp = '{name: "none", alu: 32'h0, pc: 32'h0, clr: 1'b0, ovf: 1'b0};
        drive("after_rst", 0, ALU_ADD, 32'h2, 32'h3, BR_NONE, 0, 0, 0, 32'h8, 32'h5, 32'h8, 0, 0);
        finish_issue();

        @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d expectations left, exp 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
